// File: rtl/sdes_pkg.sv
// Shared S-DES definitions: FSM/mode enums, permutation index tables,
// S-boxes and the combinational primitives (permutations, fK, SW).
// Index tables use the classic 1-based numbering where position 1 is the MSB.
package sdes_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_KEY  = 3'd1,
    S_RND1 = 3'd2,
    S_RND2 = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  typedef enum logic {
    MODE_ENC = 1'b0,
    MODE_DEC = 1'b1
  } mode_t;

  localparam int P10_IDX    [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  localparam int P8_IDX     [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};
  localparam int IP_IDX     [8]  = '{2, 6, 3, 1, 4, 8, 5, 7};
  localparam int IP_INV_IDX [8]  = '{4, 1, 3, 5, 7, 2, 8, 6};
  localparam int EP_IDX     [8]  = '{4, 1, 2, 3, 2, 3, 4, 1};
  localparam int P4_IDX     [4]  = '{2, 4, 3, 1};

  // S-boxes, row-major: index = {row, col}
  localparam logic [1:0] S0_TAB [16] = '{
    2'd1, 2'd0, 2'd3, 2'd2,
    2'd3, 2'd2, 2'd1, 2'd0,
    2'd0, 2'd2, 2'd1, 2'd3,
    2'd3, 2'd1, 2'd3, 2'd2
  };
  localparam logic [1:0] S1_TAB [16] = '{
    2'd0, 2'd1, 2'd2, 2'd3,
    2'd2, 2'd0, 2'd1, 2'd3,
    2'd3, 2'd0, 2'd1, 2'd0,
    2'd2, 2'd1, 2'd0, 2'd3
  };

  function automatic logic [9:0] p10(input logic [9:0] k);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[9-i] = k[10-P10_IDX[i]];
    return r;
  endfunction

  function automatic logic [7:0] p8(input logic [9:0] k);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = k[10-P8_IDX[i]];
    return r;
  endfunction

  function automatic logic [7:0] ip(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = x[8-IP_IDX[i]];
    return r;
  endfunction

  function automatic logic [7:0] ip_inv(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = x[8-IP_INV_IDX[i]];
    return r;
  endfunction

  function automatic logic [7:0] ep(input logic [3:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = x[4-EP_IDX[i]];
    return r;
  endfunction

  function automatic logic [3:0] p4(input logic [3:0] x);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[3-i] = x[4-P4_IDX[i]];
    return r;
  endfunction

  // fK: left nibble ^= F(right, subkey); right nibble passes through.
  // S-box row = outer bits (1,4), column = inner bits (2,3).
  function automatic logic [7:0] fk(input logic [7:0] x, input logic [7:0] sk);
    logic [7:0] t;
    logic [3:0] f;
    t = ep(x[3:0]) ^ sk;
    f = p4({S0_TAB[{t[7], t[4], t[6], t[5]}], S1_TAB[{t[3], t[0], t[2], t[1]}]});
    return {x[7:4] ^ f, x[3:0]};
  endfunction

  function automatic logic [7:0] sw(input logic [7:0] x);
    return {x[3:0], x[7:4]};
  endfunction

endpackage

// File: rtl/sdes_key_sched.sv
// Combinational S-DES key schedule: 10-bit key -> subkeys K1, K2.
// The parent registers the outputs, so no state lives here.
module sdes_key_sched
  import sdes_pkg::*;
(
  input  logic [9:0] key,
  output logic [7:0] k1,
  output logic [7:0] k2
);

  logic [9:0] p;
  logic [9:0] ls1;
  logic [9:0] ls3;

  // P10, then rotate each 5-bit half left by 1 (K1) and by a further 2 (K2)
  always_comb begin
    p   = p10(key);
    ls1 = {p[8:5], p[9], p[3:0], p[4]};
    ls3 = {ls1[7:5], ls1[9:8], ls1[2:0], ls1[4:3]};
    k1  = p8(ls1);
    k2  = p8(ls3);
  end

endmodule

// File: rtl/sdes_stream_engine.sv
// Handshaked multi-byte S-DES engine, one byte-round per clock through a
// single shared datapath. Encrypt/decrypt chosen per word at accept.
// Optional CBC chaining across lanes and words when SDES_CBC_EN is defined.
//
// Handshake: a word is taken on any rising edge where i_valid & o_ready_in;
// a result is delivered on any rising edge where o_valid & i_ready_out.
// o_ready_in is high only in IDLE; o_valid holds with o_data stable until
// its handshake, and the next word can be taken one cycle later.
module sdes_stream_engine
  import sdes_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         i_key,
  input  logic               i_mode,
  input  logic               i_valid,
  output logic               o_ready_in,
  input  logic [8*LANES-1:0] i_data,
  output logic               o_valid,
  input  logic               i_ready_out,
  output logic [8*LANES-1:0] o_data,
  output logic               o_busy,
`ifdef SDES_CBC_EN
  input  logic [7:0]         i_iv,
  input  logic               i_iv_load,
`endif
  output state_t             o_dbg_state
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  state_t             state;
  logic [LW-1:0]      lane;
  logic [8*LANES-1:0] data_q;
  logic [8*LANES-1:0] out_q;
  logic [9:0]         key_q;
  mode_t              mode_q;
  logic [7:0]         k_first_q;
  logic [7:0]         k_second_q;
  logic [7:0]         half_q;
  logic               valid_q;

  logic [7:0]         k1;
  logic [7:0]         k2;
  logic [LW+2:0]      lane_base;
  logic [7:0]         lane_in;
  logic [7:0]         rnd1_in;
  logic [7:0]         rnd2_res;
  logic [7:0]         lane_out;
`ifdef SDES_CBC_EN
  logic [7:0]         chain_q;
  logic [7:0]         chain_next;
`endif

  sdes_key_sched u_key_sched (
    .key (key_q),
    .k1  (k1),
    .k2  (k2)
  );

  // Lane datapath: chaining pre-/post-whitening around the shared rounds
  always_comb begin
    lane_base = {lane, 3'b000};
    lane_in   = data_q[lane_base +: 8];
    rnd2_res  = ip_inv(fk(half_q, k_second_q));
`ifdef SDES_CBC_EN
    if (mode_q == MODE_ENC) begin
      rnd1_in    = lane_in ^ chain_q;
      lane_out   = rnd2_res;
      chain_next = rnd2_res;
    end else begin
      rnd1_in    = lane_in;
      lane_out   = rnd2_res ^ chain_q;
      chain_next = lane_in;
    end
`else
    rnd1_in  = lane_in;
    lane_out = rnd2_res;
`endif
  end

  // Control FSM with all datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      lane       <= '0;
      data_q     <= '0;
      out_q      <= '0;
      key_q      <= '0;
      mode_q     <= MODE_ENC;
      k_first_q  <= '0;
      k_second_q <= '0;
      half_q     <= '0;
      valid_q    <= 1'b0;
`ifdef SDES_CBC_EN
      chain_q    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
`ifdef SDES_CBC_EN
          if (i_iv_load) chain_q <= i_iv;
`endif
          if (i_valid) begin
            data_q <= i_data;
            key_q  <= i_key;
            mode_q <= mode_t'(i_mode);
            lane   <= '0;
            state  <= S_KEY;
          end
        end
        S_KEY: begin
          // Decrypt applies the subkeys in reverse order
          k_first_q  <= (mode_q == MODE_DEC) ? k2 : k1;
          k_second_q <= (mode_q == MODE_DEC) ? k1 : k2;
          state      <= S_RND1;
        end
        S_RND1: begin
          half_q <= sw(fk(ip(rnd1_in), k_first_q));
          state  <= S_RND2;
        end
        S_RND2: begin
          out_q[lane_base +: 8] <= lane_out;
`ifdef SDES_CBC_EN
          chain_q <= chain_next;
`endif
          if (lane == LAST_LANE) begin
            valid_q <= 1'b1;
            state   <= S_OUT;
          end else begin
            lane  <= lane + LW'(1);
            state <= S_RND1;
          end
        end
        S_OUT: begin
          if (i_ready_out) begin
            valid_q <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_ready_in  = (state == S_IDLE);
  assign o_busy      = (state != S_IDLE);
  assign o_valid     = valid_q;
  assign o_data      = out_q;
  assign o_dbg_state = state;

endmodule

// File: tb/tb_sdes_stream_engine.sv
// Directed bench for sdes_stream_engine: one LANES=1 and one LANES=2
// instance. Build with +define+SDES_CBC_EN to exercise the chained variant.
module tb_sdes_stream_engine;
  import sdes_pkg::*;

  localparam logic [9:0] KEY = 10'b1010000010;
`ifdef SDES_CBC_EN
  // With chain = 0: lane0 E(0x97)=0x38, lane1 E(0x38^0x38)=E(0x00)=0xCE
  localparam logic [15:0] VEC_IN = 16'h3897;
`else
  localparam logic [15:0] VEC_IN = 16'h0097;
`endif
  localparam logic [15:0] VEC_OUT = 16'hCE38;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  // LANES=1 instance
  logic [9:0] d1_key;
  logic       d1_mode, d1_valid, d1_rdy, d1_ov, d1_ready_out, d1_busy;
  logic [7:0] d1_data, d1_odata;
  state_t     d1_state;

  // LANES=2 instance
  logic [9:0]  d2_key;
  logic        d2_mode, d2_valid, d2_rdy, d2_ov, d2_ready_out, d2_busy;
  logic [15:0] d2_data, d2_odata;
  state_t      d2_state;
`ifdef SDES_CBC_EN
  logic [7:0]  d2_iv;
  logic        d2_iv_load;
`endif

  sdes_stream_engine #(.LANES(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_key(d1_key), .i_mode(d1_mode),
    .i_valid(d1_valid), .o_ready_in(d1_rdy), .i_data(d1_data),
    .o_valid(d1_ov), .i_ready_out(d1_ready_out), .o_data(d1_odata),
    .o_busy(d1_busy),
`ifdef SDES_CBC_EN
    .i_iv(8'h00), .i_iv_load(1'b0),
`endif
    .o_dbg_state(d1_state)
  );

  sdes_stream_engine #(.LANES(2)) u_dut2 (
    .clk(clk), .rst(rst), .i_key(d2_key), .i_mode(d2_mode),
    .i_valid(d2_valid), .o_ready_in(d2_rdy), .i_data(d2_data),
    .o_valid(d2_ov), .i_ready_out(d2_ready_out), .o_data(d2_odata),
    .o_busy(d2_busy),
`ifdef SDES_CBC_EN
    .i_iv(d2_iv), .i_iv_load(d2_iv_load),
`endif
    .o_dbg_state(d2_state)
  );

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic run1(input logic [7:0] d, input logic m, output logic [7:0] r, output int lat);
    int n = 0;
    while (!d1_rdy && n < 50) begin @(negedge clk); n++; end
    d1_data = d; d1_key = KEY; d1_mode = m; d1_valid = 1'b1;
    @(negedge clk);
    d1_valid = 1'b0;
    lat = 0;
    while (!d1_ov && lat < 50) begin @(negedge clk); lat++; end
    r = d1_odata;
    d1_ready_out = 1'b1;
    @(negedge clk);
    d1_ready_out = 1'b0;
  endtask

  task automatic run2(input logic [15:0] d, input logic [9:0] k, input logic m,
                      input bit scramble, output logic [15:0] r, output int lat);
    int n = 0;
    while (!d2_rdy && n < 50) begin @(negedge clk); n++; end
    d2_data = d; d2_key = k; d2_mode = m; d2_valid = 1'b1;
    @(negedge clk);
    d2_valid = scramble;
    lat = 0;
    while (!d2_ov && lat < 50) begin
      if (scramble) begin
        d2_key  = 10'($urandom);
        d2_mode = ~m;
        d2_data = 16'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    d2_valid = 1'b0;
    r = d2_odata;
    d2_ready_out = 1'b1;
    @(negedge clk);
    d2_ready_out = 1'b0;
  endtask

  task automatic expect2(input string tag, input logic [15:0] d, input logic [9:0] k,
                         input logic m, input logic [15:0] e, input bit scramble);
    logic [15:0] r;
    int lat;
    exp_q.push_back(e);
    run2(d, k, m, scramble, r, lat);
    check_eq(tag, 32'(r), 32'(exp_q.pop_front()));
    check_eq({tag, "_lat"}, 32'(lat), 32'd5);
  endtask

`ifdef SDES_CBC_EN
  task automatic load_iv(input logic [7:0] v);
    d2_iv = v; d2_iv_load = 1'b1;
    @(negedge clk);
    d2_iv_load = 1'b0;
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  r1;
    logic [15:0] c, p, held, c1, c2, p1, p2;
    logic [9:0]  rk;
    int lat, nbad;

    rst = 1'b1;
    d1_key = '0; d1_mode = 1'b0; d1_valid = 1'b0; d1_data = '0; d1_ready_out = 1'b0;
    d2_key = '0; d2_mode = 1'b0; d2_valid = 1'b0; d2_data = '0; d2_ready_out = 1'b0;
`ifdef SDES_CBC_EN
    d2_iv = '0; d2_iv_load = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_eq("rst_valid", 32'(d2_ov), 32'd0);
    check_eq("rst_data", 32'(d2_odata), 32'd0);
    check_eq("rst_busy", 32'(d2_busy), 32'd0);
    check_eq("rst_ready", 32'(d2_rdy), 32'd1);
    check_eq("rst_data1", 32'(d1_odata), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_ready", 32'(d2_rdy), 32'd1);

`ifndef SDES_CBC_EN
    // LANES=1 known vector both directions
    run1(8'h97, 1'b0, r1, lat);
    check_eq("l1_enc", 32'(r1), 32'h38);
    check_eq("l1_enc_lat", 32'(lat), 32'd3);
    run1(8'h38, 1'b1, r1, lat);
    check_eq("l1_dec", 32'(r1), 32'h97);

    // LANES=2 directed vectors (E(0x97)=0x38, E(0x00)=0xCE under KEY)
    expect2("l2_enc_9797", 16'h9797, KEY, 1'b0, 16'h3838, 1'b0);
    expect2("l2_enc_0097", 16'h0097, KEY, 1'b0, 16'hCE38, 1'b0);
    expect2("l2_dec_38ce", 16'h38CE, KEY, 1'b1, 16'h9700, 1'b0);
    expect2("l2_dec_3838", 16'h3838, KEY, 1'b1, 16'h9797, 1'b0);
    expect2("l2_scramble", 16'h0097, KEY, 1'b0, 16'hCE38, 1'b1);
    expect2("l2_scr_dec", 16'h38CE, KEY, 1'b1, 16'h9700, 1'b1);
`else
    // Chained vectors: chain 0 -> word1, chain carries into word2
    load_iv(8'h00);
    expect2("cbc_enc1", 16'h3897, KEY, 1'b0, 16'hCE38, 1'b0);
    expect2("cbc_enc2", 16'h59CE, KEY, 1'b0, 16'h38CE, 1'b0);
    load_iv(8'h00);
    expect2("cbc_dec1", 16'hCE38, KEY, 1'b1, 16'h3897, 1'b0);
    expect2("cbc_dec2", 16'h38CE, KEY, 1'b1, 16'h59CE, 1'b0);
    load_iv(8'h00);
    expect2("cbc_scramble", 16'h3897, KEY, 1'b0, 16'hCE38, 1'b1);
    // Random words: encrypt two, decrypt two, then corrupt one ciphertext byte
    p1 = 16'($urandom); p2 = 16'($urandom); rk = 10'($urandom);
    load_iv(8'h5A);
    run2(p1, rk, 1'b0, 1'b0, c1, lat);
    run2(p2, rk, 1'b0, 1'b0, c2, lat);
    load_iv(8'h5A);
    expect2("cbc_rt1", c1, rk, 1'b1, p1, 1'b0);
    expect2("cbc_rt2", c2, rk, 1'b1, p2, 1'b0);
    load_iv(8'h5A);
    run2(c1 ^ 16'h0001, rk, 1'b1, 1'b0, p, lat);
    run2(c2, rk, 1'b1, 1'b0, c, lat);
    nbad = 0;
    for (int i = 0; i < 2; i++) begin
      if (p[8*i +: 8] != p1[8*i +: 8]) nbad++;
      if (c[8*i +: 8] != p2[8*i +: 8]) nbad++;
    end
    check_eq("cbc_corrupt_bytes", 32'(nbad), 32'd2);
`endif

    // Random round trips
    for (int i = 0; i < 4; i++) begin
      rk = 10'($urandom_range(0, 1023));
      p  = 16'($urandom);
`ifdef SDES_CBC_EN
      load_iv(8'($urandom));
      d2_iv = d2_iv;
      run2(p, rk, 1'b0, 1'b0, c, lat);
      load_iv(d2_iv);
`else
      run2(p, rk, 1'b0, 1'b0, c, lat);
`endif
      expect2("roundtrip", c, rk, 1'b1, p, 1'b0);
    end

    // Back-pressure: hold result 10 cycles, offer a competing word meanwhile
`ifdef SDES_CBC_EN
    load_iv(8'h00);
`endif
    d2_data = VEC_IN; d2_key = KEY; d2_mode = 1'b0; d2_valid = 1'b1;
    @(negedge clk);
    d2_valid = 1'b0;
    lat = 0;
    while (!d2_ov && lat < 50) begin @(negedge clk); lat++; end
    check_eq("bp_lat", 32'(lat), 32'd5);
    held = d2_odata;
    check_eq("bp_data", 32'(held), 32'(VEC_OUT));
    d2_data = 16'hFFFF; d2_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_stable", 32'(d2_odata), 32'(VEC_OUT));
      check_eq("bp_ready_in", 32'(d2_rdy), 32'd0);
      check_eq("bp_valid", 32'(d2_ov), 32'd1);
    end
    d2_valid = 1'b0; d2_ready_out = 1'b1;
    @(negedge clk);
    d2_ready_out = 1'b0;
    check_eq("bp_after_ready", 32'(d2_rdy), 32'd1);
    check_eq("bp_after_busy", 32'(d2_busy), 32'd0);
    check_eq("bp_after_valid", 32'(d2_ov), 32'd0);

    // Reset during RND2 of lane 1 discards the word
    d2_data = 16'hFFFF; d2_key = KEY; d2_mode = 1'b0; d2_valid = 1'b1;
    @(negedge clk);
    d2_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("pre_rst_state", 32'(d2_state), 32'(S_RND2));
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_valid", 32'(d2_ov), 32'd0);
    check_eq("mid_rst_busy", 32'(d2_busy), 32'd0);
    check_eq("mid_rst_data", 32'(d2_odata), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    expect2("post_rst", VEC_IN, KEY, 1'b0, VEC_OUT, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout: got no finish, expected finish before bound");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdes_stream_engine.md
# sdes_stream_engine

Parametrised, handshaked S-DES engine that processes a multi-byte word one byte-round per clock through a single shared datapath, in encrypt or decrypt mode selected per word. It succeeds the fixed 8-bit encoder/decoder pair: one core serves both directions, supports back-pressure and, optionally, CBC chaining across bytes and words. It sits between a byte-stream source and sink inside the cipher subsystem.

## Interface
- LANES, default 2: bytes per word (1..16); lane 0 = bits [7:0], processed first.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_key  in  10  S-DES key, sampled on the accepting edge only.
- i_mode  in  1  0 = encrypt, 1 = decrypt, sampled on the accepting edge.
- i_valid  in  1  input word valid.
- o_ready_in  out  1  engine can accept a word.
- i_data  in  8*LANES  plaintext (encrypt) or ciphertext (decrypt).
- o_valid  out  1  result word valid.
- i_ready_out  in  1  sink accepts result.
- o_data  out  8*LANES  result word.
- o_busy  out  1  a word is in flight (state not IDLE).
- i_iv  in  8  CBC initial value (only with SDES_CBC_EN).
- i_iv_load  in  1  load i_iv into chain register (only with SDES_CBC_EN).

## Operation
- FSM states: IDLE, KEY, RND1, RND2, OUT.
- IDLE: o_ready_in = 1 only in IDLE. Accept when i_valid & o_ready_in: latch i_data, i_key, i_mode; lane counter = 0; go KEY.
- KEY: register subkeys K1, K2 (P10, LS1, P8; LS2, P8). Decrypt swaps their use order. Go RND1.
- RND1: current lane: IP, fK with first subkey, SW; store half-result. Go RND2.
- RND2: fK with second subkey, IP^-1; write lane result into output register. If lane = LANES-1, go OUT, else lane+1, go RND1.
- OUT: o_valid = 1, o_data stable until i_valid_out handshake (o_valid & i_ready_out); then IDLE.
- Key/mode/data changes while not IDLE have no effect on the word in flight.
- No input accepted in OUT; next word accepted earliest the cycle after the output handshake.
- rst at any time: state IDLE, lane 0, all data/key/chain registers 0, o_valid 0, o_busy 0, o_ready_in 1 after release. Word in flight is discarded.

## Timing
- Accepting edge = edge 0. KEY at edge 1; rounds at edges 2..2·LANES+1; o_valid visible after edge 2·LANES+1.
- Latency accept-to-o_valid: 2·LANES+1 cycles (LANES=2: 5).
- Throughput: one word per 2·LANES+3 cycles with i_ready_out held high.
- Reset values: o_valid 0, o_data 0, o_busy 0, o_ready_in 1.

## Configuration
- SDES_CBC_EN defined: i_iv/i_iv_load ports exist; 8-bit chain register C. Encrypt lane: out = E(in ^ C), C = out. Decrypt lane: out = D(in) ^ C, C = in. Chain carries across lanes and words. i_iv_load in IDLE loads C; ignored outside IDLE. Load and accept in same cycle: load takes effect first for that word.
- Not defined: ECB, each lane independent, no chain register, no iv ports.

## Structure
- Package sdes_pkg: P10, P8, IP, IP_INV, EP, P4 index constants, S0/S1 tables, state enum, mode enum, permutation/fK functions.
- Sub-module sdes_key_sched: combinational 10-bit key to K1/K2; registered in parent.

## Test plan
- LANES=1, key 1010000010, encrypt 10010111 -> o_data 00111000 after 3 cycles; decrypt 00111000 -> 10010111.
- LANES=2, key 1010000010, encrypt 16'h9797 -> 16'h3838, o_valid 5 cycles after accept.
- Back-pressure: i_ready_out low 10 cycles in OUT -> o_data stable, o_ready_in 0, new i_valid ignored.
- Reset asserted in RND2 of lane 1 -> next cycle o_valid 0, o_busy 0; fresh word afterwards correct.
- i_key/i_mode toggled during rounds -> result matches values sampled at accept.
- SDES_CBC_EN: iv 8'h00 load, encrypt two 16-bit words, then reload iv, decrypt ciphertexts -> original plaintext; altering one ciphertext byte corrupts exactly two plaintext bytes.
